// File: rtl/shared_data_memory.sv
// shared_data_memory: word-addressed shared data RAM with out-of-range error tracking
//   and an optional test-and-set semaphore window (macro SHARED_MEM_SEMAPHORE_EN).
// Ports:
//   clock, reset_n      - clock and asynchronous active-low reset
//   shared_addr         - byte address from the arbiter, bits [1:0] ignored
//   shared_write        - 1 = write this cycle, 0 = read
//   shared_writedata    - write data
//   shared_readdata     - registered read data (write-first on writes)
//   err_flag, err_count - sticky error flag and saturating error count
//   sem_status          - bit i = semaphore i held (0 without the macro)
module shared_data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
    parameter logic [31:0] SEM_BASE    = 32'hFFFF_FF00,
    parameter int unsigned NUM_SEM     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] shared_addr,
    input  logic        shared_write,
    input  logic [31:0] shared_writedata,
    output logic [31:0] shared_readdata,
    output logic        err_flag,
    output logic [7:0]  err_count,
    output logic [31:0] sem_status
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          in_ram, sem_hit, err, wr_ram;
    logic [31:0]   rdata_q, rdata_d;
    logic          flag_q, flag_d;
    logic [7:0]    cnt_q, cnt_d;
    assign idx    = shared_addr[AW+1:2];
    assign in_ram = shared_addr[31:AW+2] == '0;
    assign err    = !in_ram && !sem_hit;
    assign wr_ram = shared_write && in_ram && !sem_hit;
`ifdef SHARED_MEM_SEMAPHORE_EN
    logic [31:0] sem_off, sem_q, sem_d, prev_addr_q;
    logic [4:0]  sem_idx;
    logic        prev_wr_q, new_acc;
    assign sem_off    = {shared_addr[31:2], 2'b00} - SEM_BASE;
    assign sem_hit    = sem_off[1:0] == 2'b00 && {2'b00, sem_off[31:2]} < NUM_SEM;
    assign sem_idx    = sem_off[6:2];
    // A held read address must not re-trigger test-and-set; a preceding write always re-arms it.
    assign new_acc    = prev_wr_q || shared_addr != prev_addr_q;
    assign sem_status = sem_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_addr_q <= '0;
            prev_wr_q   <= 1'b1;
            sem_q       <= '0;
        end else begin
            prev_addr_q <= shared_addr;
            prev_wr_q   <= shared_write;
            sem_q       <= sem_d;
        end
    end
`else
    logic unused_ok;
    assign unused_ok  = ^{shared_addr[1:0], SEM_BASE, 32'(NUM_SEM)};
    assign sem_hit    = 1'b0;
    assign sem_status = '0;
`endif
    always_ff @(posedge clock) begin
        if (wr_ram) mem[idx] <= shared_writedata;
    end
    always_comb begin
        rdata_d = err ? ERR_DATA : shared_write ? shared_writedata : mem[idx];
        flag_d  = flag_q | err;
        cnt_d   = cnt_q + 8'(err && cnt_q != 8'hFF);
`ifdef SHARED_MEM_SEMAPHORE_EN
        sem_d = sem_q;
        if (sem_hit) begin
            if (shared_write) begin
                sem_d[sem_idx] = shared_writedata[0];
                rdata_d        = {31'b0, shared_writedata[0]};
            end else if (new_acc) begin
                rdata_d        = {31'b0, sem_q[sem_idx]};
                sem_d[sem_idx] = 1'b1;
            end else begin
                rdata_d = rdata_q;
            end
        end
`endif
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end
    assign shared_readdata = rdata_q;
    assign err_flag        = flag_q;
    assign err_count       = cnt_q;
endmodule
